// File: rtl/bp_cce_hybrid_lce_resp_pipe_mc.sv
// rtl/bp_cce_hybrid_lce_resp_pipe_mc.sv - multi-channel LCE response pipe with pending-write queue
//
// Purpose: round-robin arbitration over num_ch_p LCE response channels, each buffered
// by a small header FIFO. Writebacks are streamed to the memory command port; all other
// responses become single-cycle consume pulses. Pending-bit updates are buffered in a
// pending_els_p-deep queue. A writeback stream reserves a queue entry when its first beat
// is sent and fills that entry on its last beat.
//
// Optional feature: define BP_CCE_RESP_PIPE_PERF_EN to add the saturating counters
// wb_count_o, coh_count_o and pending_full_stall_o.
//
// Header layout (LSB first): msg_type[3], subop[4], addr[paddr_width_p], size[3], src_id[lce_id_width_p].
// The memory command header uses the same layout with msg_type = write (3'b001).
//
// Ports:
//   clk_i, reset_i                        clock, synchronous active-high reset
//   lce_resp_header_* / lce_resp_data_*  per-channel response inputs (packed per channel)
//   lce_resp_last_i                       unused
//   mem_cmd_*                             writeback data stream out
//   pending_w_*, pending_up/down/clear_o  pending-write queue head
//   *_yumi_o, resp_ch_o, resp_lce_id_o    consume pulses with channel and source LCE id
//   resp_error_o                          pulse on an unrecognised msg_type
module bp_cce_hybrid_lce_resp_pipe_mc
  #(parameter int paddr_width_p     = 40
   ,parameter int lce_id_width_p    = 4
   ,parameter int cce_block_width_p = 512
   ,parameter int lce_data_width_p  = 64
   ,parameter int mem_data_width_p  = 64
   ,parameter int num_ch_p          = 2
   ,parameter int header_els_p      = 2
   ,parameter int pending_els_p     = 4
   ,localparam int hdr_w = 3 + 4 + paddr_width_p + 3 + lce_id_width_p
   ,localparam int ch_w  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
   )
  (input  logic                                   clk_i
   ,input  logic                                  reset_i
   ,input  logic [num_ch_p*hdr_w-1:0]             lce_resp_header_i
   ,input  logic [num_ch_p-1:0]                   lce_resp_header_v_i
   ,output logic [num_ch_p-1:0]                   lce_resp_header_ready_and_o
   ,input  logic [num_ch_p-1:0]                   lce_resp_has_data_i
   ,input  logic [num_ch_p*lce_data_width_p-1:0]  lce_resp_data_i
   ,input  logic [num_ch_p-1:0]                   lce_resp_data_v_i
   ,output logic [num_ch_p-1:0]                   lce_resp_data_ready_and_o
   ,input  logic [num_ch_p-1:0]                   lce_resp_last_i
   ,output logic [hdr_w-1:0]                      mem_cmd_header_o
   ,output logic [mem_data_width_p-1:0]           mem_cmd_data_o
   ,output logic                                  mem_cmd_v_o
   ,input  logic                                  mem_cmd_ready_and_i
   ,output logic                                  mem_cmd_last_o
   ,output logic                                  pending_w_v_o
   ,input  logic                                  pending_w_yumi_i
   ,output logic [paddr_width_p-1:0]              pending_w_addr_o
   ,output logic                                  pending_w_addr_bypass_hash_o
   ,output logic                                  pending_up_o
   ,output logic                                  pending_down_o
   ,output logic                                  pending_clear_o
   ,output logic                                  sync_yumi_o
   ,output logic                                  inv_yumi_o
   ,output logic                                  coh_yumi_o
   ,output logic                                  wb_yumi_o
   ,output logic [ch_w-1:0]                       resp_ch_o
   ,output logic [lce_id_width_p-1:0]             resp_lce_id_o
   ,output logic                                  resp_error_o
`ifdef BP_CCE_RESP_PIPE_PERF_EN
   ,output logic [31:0]                           wb_count_o
   ,output logic [31:0]                           coh_count_o
   ,output logic [31:0]                           pending_full_stall_o
`endif
   );

   localparam int hp_w     = (header_els_p > 1) ? $clog2(header_els_p) : 1;
   localparam int hc_w     = $clog2(header_els_p + 1);
   localparam int pp_w     = (pending_els_p > 1) ? $clog2(pending_els_p) : 1;
   localparam int pc_w     = $clog2(pending_els_p + 1);
   localparam int beat_w   = $clog2(cce_block_width_p / mem_data_width_p + 1);
   localparam int addr_lsb = 7;
   localparam int size_lsb = addr_lsb + paddr_width_p;
   localparam int src_lsb  = size_lsb + 3;

   localparam logic [2:0] resp_sync_ack = 3'd0;
   localparam logic [2:0] resp_inv_ack  = 3'd1;
   localparam logic [2:0] resp_coh_ack  = 3'd2;
   localparam logic [2:0] resp_wb       = 3'd3;
   localparam logic [2:0] resp_null_wb  = 3'd4;
   localparam logic [2:0] mem_wr        = 3'b001;

   // per-channel header FIFOs; entry = {has_data, header}
   logic [hdr_w:0]      hfifo_mem [num_ch_p][header_els_p];
   logic [hp_w-1:0]     hfifo_rd  [num_ch_p];
   logic [hp_w-1:0]     hfifo_wr  [num_ch_p];
   logic [hc_w-1:0]     hfifo_cnt [num_ch_p];
   logic [num_ch_p-1:0] head_v, hfifo_enq, hfifo_deq;

   // pending queue; entry = {addr, up}
   logic [paddr_width_p:0] pq_mem [pending_els_p];
   logic [pp_w-1:0]        pq_rd, pq_wr;
   logic [pc_w-1:0]        pq_occ, pq_resv;
   logic                   pq_deq, pq_space, pq_enq, enq_up;

   logic [ch_w-1:0]        rr_ptr, lock_ch, gnt;
   logic                   locked, found;
   int                     idx, stream_bits;
   logic [beat_w-1:0]      beat, last_beat;
   logic [hdr_w:0]         hd;
   logic [2:0]             mtype;
   logic                   gv, yumi, is_wb, go, beat_fire, start, done, stall, pulse;
   logic [lce_data_width_p-1:0] sel_data;
   logic                   unused_ok;

   function automatic logic [hp_w-1:0] hinc(input logic [hp_w-1:0] p);
      return (p == hp_w'(header_els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [pp_w-1:0] pinc(input logic [pp_w-1:0] p);
      return (p == pp_w'(pending_els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      for (int c = 0; c < num_ch_p; c++) begin
         head_v[c] = (hfifo_cnt[c] != '0);
         lce_resp_header_ready_and_o[c] = (hfifo_cnt[c] != hc_w'(header_els_p));
         hfifo_enq[c] = lce_resp_header_v_i[c] & lce_resp_header_ready_and_o[c];
      end
   end

   // round-robin search starting at rr_ptr, overridden by the lock during a stream
   always_comb begin
      gnt   = lock_ch;
      found = 1'b0;
      idx   = 0;
      if (!locked) begin
         gnt = rr_ptr;
         for (int i = 0; i < num_ch_p; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= num_ch_p) idx = idx - num_ch_p;
            if (!found && head_v[ch_w'(idx)]) begin
               gnt   = ch_w'(idx);
               found = 1'b1;
            end
         end
      end
   end

   assign gv       = head_v[gnt];
   assign hd       = hfifo_mem[gnt][hfifo_rd[gnt]];
   assign mtype    = hd[2:0];
   assign sel_data = lce_resp_data_i[int'(gnt)*lce_data_width_p +: lce_data_width_p];
   assign is_wb    = gv & (mtype == resp_wb);

   assign pq_deq   = pending_w_yumi_i & (pq_occ != '0);
   // a same-cycle dequeue frees the slot the enqueue needs
   assign pq_space = ((int'(pq_occ) + int'(pq_resv)) < pending_els_p) | pq_deq;

   always_comb begin
      stream_bits = 8 << hd[size_lsb +: 3];
      last_beat   = (stream_bits <= mem_data_width_p) ? '0
                    : beat_w'(stream_bits / mem_data_width_p - 1);
   end

   always_comb begin
      yumi = 1'b0; sync_yumi_o = 1'b0; inv_yumi_o = 1'b0; coh_yumi_o = 1'b0;
      wb_yumi_o = 1'b0; resp_error_o = 1'b0; pq_enq = 1'b0; enq_up = 1'b0;
      go = 1'b0; mem_cmd_v_o = 1'b0; beat_fire = 1'b0; start = 1'b0; done = 1'b0;
      stall = 1'b0; lce_resp_data_ready_and_o = '0;
      if (gv) begin
         case (mtype)
            resp_sync_ack: begin yumi = 1'b1; sync_yumi_o = 1'b1; end
            resp_inv_ack:  begin yumi = 1'b1; inv_yumi_o  = 1'b1; end
            resp_null_wb:  begin yumi = 1'b1; wb_yumi_o   = 1'b1; end
            resp_coh_ack: begin
               if (pq_space) begin
                  yumi = 1'b1; coh_yumi_o = 1'b1; pq_enq = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end
            resp_wb: begin
               // the first beat needs a free queue entry; later beats already hold one
               go = locked | pq_space;
               mem_cmd_v_o = lce_resp_data_v_i[gnt] & go;
               lce_resp_data_ready_and_o[gnt] = mem_cmd_ready_and_i & go;
               beat_fire = mem_cmd_v_o & mem_cmd_ready_and_i;
               start = beat_fire & ~locked;
               done  = beat_fire & (beat == last_beat);
               stall = ~go & lce_resp_data_v_i[gnt] & mem_cmd_ready_and_i;
               if (done) begin
                  yumi = 1'b1; wb_yumi_o = 1'b1; pq_enq = 1'b1; enq_up = 1'b1;
               end
            end
            default: begin yumi = 1'b1; resp_error_o = 1'b1; end
         endcase
      end
   end

   always_comb begin
      for (int c = 0; c < num_ch_p; c++)
         hfifo_deq[c] = yumi & (gnt == ch_w'(c));
   end

   assign pulse          = sync_yumi_o | inv_yumi_o | coh_yumi_o | wb_yumi_o | resp_error_o;
   assign resp_ch_o      = pulse ? gnt : '0;
   assign resp_lce_id_o  = pulse ? hd[src_lsb +: lce_id_width_p] : '0;
   assign mem_cmd_header_o = is_wb ? {hd[hdr_w-1:3], mem_wr} : '0;
   assign mem_cmd_data_o   = is_wb ? sel_data : '0;
   assign mem_cmd_last_o   = mem_cmd_v_o & (beat == last_beat);

   assign pending_w_v_o    = (pq_occ != '0);
   assign pending_w_addr_o = pending_w_v_o ? pq_mem[pq_rd][paddr_width_p:1] : '0;
   assign pending_up_o     = pending_w_v_o & pq_mem[pq_rd][0];
   assign pending_down_o   = pending_w_v_o & ~pq_mem[pq_rd][0];
   assign pending_w_addr_bypass_hash_o = 1'b0;
   assign pending_clear_o  = 1'b0;
   assign unused_ok        = ^{lce_resp_last_i, hd[hdr_w]};

   always_ff @(posedge clk_i) begin
      for (int c = 0; c < num_ch_p; c++)
         if (hfifo_enq[c])
            hfifo_mem[c][hfifo_wr[c]] <= {lce_resp_has_data_i[c], lce_resp_header_i[c*hdr_w +: hdr_w]};
      if (pq_enq)
         pq_mem[pq_wr] <= {hd[addr_lsb +: paddr_width_p], enq_up};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int c = 0; c < num_ch_p; c++) begin
            hfifo_rd[c]  <= '0;
            hfifo_wr[c]  <= '0;
            hfifo_cnt[c] <= '0;
         end
         rr_ptr <= '0; lock_ch <= '0; locked <= 1'b0; beat <= '0;
         pq_rd <= '0; pq_wr <= '0; pq_occ <= '0; pq_resv <= '0;
      end else begin
         for (int c = 0; c < num_ch_p; c++) begin
            if (hfifo_enq[c]) hfifo_wr[c] <= hinc(hfifo_wr[c]);
            if (hfifo_deq[c]) hfifo_rd[c] <= hinc(hfifo_rd[c]);
            hfifo_cnt[c] <= hfifo_cnt[c] + hc_w'(hfifo_enq[c]) - hc_w'(hfifo_deq[c]);
         end
         if (yumi)
            rr_ptr <= (gnt == ch_w'(num_ch_p - 1)) ? '0 : gnt + 1'b1;
         if (done)       locked <= 1'b0;
         else if (start) locked <= 1'b1;
         if (start) lock_ch <= gnt;
         if (done)           beat <= '0;
         else if (beat_fire) beat <= beat + 1'b1;
         if (pq_enq) pq_wr <= pinc(pq_wr);
         if (pq_deq) pq_rd <= pinc(pq_rd);
         pq_occ <= pq_occ + pc_w'(pq_enq) - pc_w'(pq_deq);
         // a stream's reserved entry turns into a real entry on its last beat
         pq_resv <= pq_resv + pc_w'(start) - pc_w'(done);
      end
   end

`ifdef BP_CCE_RESP_PIPE_PERF_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wb_count_o <= '0; coh_count_o <= '0; pending_full_stall_o <= '0;
      end else begin
         if (done && wb_count_o != '1)           wb_count_o <= wb_count_o + 1'b1;
         if (coh_yumi_o && coh_count_o != '1)    coh_count_o <= coh_count_o + 1'b1;
         if (stall && pending_full_stall_o != '1) pending_full_stall_o <= pending_full_stall_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_lce_resp_pipe_mc.sv
// tb/tb_bp_cce_hybrid_lce_resp_pipe_mc.sv - directed bench for the multi-channel LCE response pipe
module tb_bp_cce_hybrid_lce_resp_pipe_mc;

   localparam logic [2:0] SYNC = 3'd0, INV = 3'd1, COH = 3'd2, WB = 3'd3;

   logic         clk = 1'b0;
   logic         reset;
   logic [59:0]  hdr_in;
   logic [1:0]   hdr_v, hdr_rdy, has_data, data_v, data_rdy, last_in;
   logic [127:0] data_in;
   logic [29:0]  mem_hdr;
   logic [63:0]  mem_data;
   logic         mem_v, mem_ready, mem_last;
   logic         pw_v, pw_yumi, bypass, up, down, clear;
   logic [15:0]  pw_addr;
   logic         sync_y, inv_y, coh_y, wb_y, err;
   logic [0:0]   resp_ch;
   logic [3:0]   resp_id;
`ifdef BP_CCE_RESP_PIPE_PERF_EN
   logic [31:0]  wb_cnt, coh_cnt, stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bp_cce_hybrid_lce_resp_pipe_mc
     #(.paddr_width_p(16), .lce_id_width_p(4), .cce_block_width_p(512)
      ,.lce_data_width_p(64), .mem_data_width_p(64), .num_ch_p(2)
      ,.header_els_p(2), .pending_els_p(2))
   dut
     (.clk_i(clk), .reset_i(reset)
      ,.lce_resp_header_i(hdr_in), .lce_resp_header_v_i(hdr_v)
      ,.lce_resp_header_ready_and_o(hdr_rdy), .lce_resp_has_data_i(has_data)
      ,.lce_resp_data_i(data_in), .lce_resp_data_v_i(data_v)
      ,.lce_resp_data_ready_and_o(data_rdy), .lce_resp_last_i(last_in)
      ,.mem_cmd_header_o(mem_hdr), .mem_cmd_data_o(mem_data), .mem_cmd_v_o(mem_v)
      ,.mem_cmd_ready_and_i(mem_ready), .mem_cmd_last_o(mem_last)
      ,.pending_w_v_o(pw_v), .pending_w_yumi_i(pw_yumi), .pending_w_addr_o(pw_addr)
      ,.pending_w_addr_bypass_hash_o(bypass), .pending_up_o(up), .pending_down_o(down)
      ,.pending_clear_o(clear), .sync_yumi_o(sync_y), .inv_yumi_o(inv_y)
      ,.coh_yumi_o(coh_y), .wb_yumi_o(wb_y), .resp_ch_o(resp_ch)
      ,.resp_lce_id_o(resp_id), .resp_error_o(err)
`ifdef BP_CCE_RESP_PIPE_PERF_EN
      ,.wb_count_o(wb_cnt), .coh_count_o(coh_cnt), .pending_full_stall_o(stall_cnt)
`endif
      );

   function automatic logic [29:0] mk(input logic [2:0] t, input logic [15:0] a,
                                      input logic [2:0] sz, input logic [3:0] id);
      return {id, sz, a, 4'h0, t};
   endfunction

   function automatic logic [63:0] pat(input int k);
      return {32'hDA7A0000 + k, 32'h0000BEEF ^ k};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (hdr_rdy !== 2'b11) begin n_bad++; $display("FAIL reset_ready: got %b want 11", hdr_rdy); end
      n_cmp++; if (pw_v !== 1'b0) begin n_bad++; $display("FAIL reset_pw_v: got %b want 0", pw_v); end
      n_cmp++; if ({mem_v, mem_last, data_rdy} !== 4'b0) begin n_bad++; $display("FAIL reset_mem: got %b want 0000", {mem_v, mem_last, data_rdy}); end
      n_cmp++; if ({sync_y, inv_y, coh_y, wb_y, err} !== 5'b0) begin n_bad++; $display("FAIL reset_pulses: got %b want 00000", {sync_y, inv_y, coh_y, wb_y, err}); end
      n_cmp++; if ({bypass, clear, up, down} !== 4'b0) begin n_bad++; $display("FAIL reset_pending_flags: got %b want 0000", {bypass, clear, up, down}); end
   endtask

   task automatic test_sync_inv();
      hdr_in = {mk(INV, 16'h0, 3'd0, 4'd2), mk(SYNC, 16'h0, 3'd0, 4'd1)};
      hdr_v = 2'b11;
      step(); hdr_v = 2'b00; #1;
      n_cmp++; if ({sync_y, inv_y, resp_ch, resp_id} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin n_bad++; $display("FAIL sync_first: got s%b i%b ch%0d id%0d want s1 i0 ch0 id1", sync_y, inv_y, resp_ch, resp_id); end
      step(); #1;
      n_cmp++; if ({sync_y, inv_y, resp_ch, resp_id} !== {1'b0, 1'b1, 1'b1, 4'd2}) begin n_bad++; $display("FAIL inv_second: got s%b i%b ch%0d id%0d want s0 i1 ch1 id2", sync_y, inv_y, resp_ch, resp_id); end
      step(); #1;
      n_cmp++; if ({sync_y, inv_y, coh_y, wb_y, err} !== 5'b0) begin n_bad++; $display("FAIL sync_inv_idle: got %b want 00000", {sync_y, inv_y, coh_y, wb_y, err}); end
   endtask

   task automatic test_wb();
      hdr_in = {mk(SYNC, 16'h0, 3'd0, 4'd5), mk(WB, 16'h1000, 3'd6, 4'd3)};
      hdr_v = 2'b11; has_data = 2'b01; data_v = 2'b01; data_in[63:0] = pat(0); mem_ready = 1'b1;
      step(); hdr_v = 2'b00; has_data = 2'b00;
      for (int k = 0; k < 8; k++) begin
         data_in[63:0] = pat(k);
         #1;
         if (k == 0) begin
            n_cmp++; if (mem_hdr !== {4'd3, 3'd6, 16'h1000, 4'h0, 3'b001}) begin n_bad++; $display("FAIL wb_header: got %h want %h", mem_hdr, {4'd3, 3'd6, 16'h1000, 4'h0, 3'b001}); end
         end
         n_cmp++; if ({mem_v, data_rdy} !== 3'b101) begin n_bad++; $display("FAIL wb_handshake beat %0d: got v%b rdy%b want v1 rdy01", k, mem_v, data_rdy); end
         n_cmp++; if (mem_data !== pat(k)) begin n_bad++; $display("FAIL wb_data beat %0d: got %h want %h", k, mem_data, pat(k)); end
         n_cmp++; if ({mem_last, wb_y, sync_y} !== {(k == 7), (k == 7), 1'b0}) begin n_bad++; $display("FAIL wb_last_yumi beat %0d: got last%b wb%b sync%b want last%b wb%b sync0", k, mem_last, wb_y, sync_y, (k == 7), (k == 7)); end
         step();
      end
      data_v = 2'b00; #1;
      n_cmp++; if ({sync_y, resp_ch, resp_id, mem_v} !== {1'b1, 1'b1, 4'd5, 1'b0}) begin n_bad++; $display("FAIL wb_then_sync: got s%b ch%0d id%0d v%b want s1 ch1 id5 v0", sync_y, resp_ch, resp_id, mem_v); end
      n_cmp++; if ({pw_v, pw_addr, up, down} !== {1'b1, 16'h1000, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wb_pending: got v%b a%h up%b dn%b want v1 a1000 up1 dn0", pw_v, pw_addr, up, down); end
      step(); pw_yumi = 1'b1;
      step(); pw_yumi = 1'b0; #1;
      n_cmp++; if (pw_v !== 1'b0) begin n_bad++; $display("FAIL wb_drain: got %b want 0", pw_v); end
   endtask

   task automatic test_coh_full();
      hdr_in = {mk(COH, 16'h0080, 3'd0, 4'd1), mk(COH, 16'h0040, 3'd0, 4'd0)};
      hdr_v = 2'b11;
      step(); hdr_in[29:0] = mk(COH, 16'h00C0, 3'd0, 4'd0); hdr_v = 2'b01; #1;
      n_cmp++; if ({coh_y, resp_ch} !== 2'b10) begin n_bad++; $display("FAIL coh1: got c%b ch%0d want c1 ch0", coh_y, resp_ch); end
      step(); hdr_v = 2'b00; #1;
      n_cmp++; if ({coh_y, resp_ch} !== 2'b11) begin n_bad++; $display("FAIL coh2: got c%b ch%0d want c1 ch1", coh_y, resp_ch); end
      n_cmp++; if ({pw_v, pw_addr, down} !== {1'b1, 16'h0040, 1'b1}) begin n_bad++; $display("FAIL coh_head: got v%b a%h dn%b want v1 a0040 dn1", pw_v, pw_addr, down); end
      step(); #1;
      n_cmp++; if (coh_y !== 1'b0) begin n_bad++; $display("FAIL coh3_held_a: got %b want 0", coh_y); end
      step(); #1;
      n_cmp++; if (coh_y !== 1'b0) begin n_bad++; $display("FAIL coh3_held_b: got %b want 0", coh_y); end
      step(); pw_yumi = 1'b1; #1;
      n_cmp++; if ({coh_y, resp_ch, pw_addr} !== {1'b1, 1'b0, 16'h0040}) begin n_bad++; $display("FAIL coh3_release: got c%b ch%0d a%h want c1 ch0 a0040", coh_y, resp_ch, pw_addr); end
      step(); #1;
      n_cmp++; if ({coh_y, pw_addr} !== {1'b0, 16'h0080}) begin n_bad++; $display("FAIL coh_q2: got c%b a%h want c0 a0080", coh_y, pw_addr); end
      step(); #1;
      n_cmp++; if ({pw_v, pw_addr} !== {1'b1, 16'h00C0}) begin n_bad++; $display("FAIL coh_q3: got v%b a%h want v1 a00c0", pw_v, pw_addr); end
      step(); pw_yumi = 1'b0; #1;
      n_cmp++; if (pw_v !== 1'b0) begin n_bad++; $display("FAIL coh_drain: got %b want 0", pw_v); end
`ifdef BP_CCE_RESP_PIPE_PERF_EN
      n_cmp++; if ({wb_cnt, coh_cnt, stall_cnt} !== {32'd1, 32'd3, 32'd2}) begin n_bad++; $display("FAIL perf_counts: got wb%0d coh%0d stall%0d want wb1 coh3 stall2", wb_cnt, coh_cnt, stall_cnt); end
`endif
   endtask

   task automatic test_unknown();
      hdr_in[59:30] = mk(3'd7, 16'h0100, 3'd0, 4'd6);
      hdr_v = 2'b10;
      step(); hdr_v = 2'b00; #1;
      n_cmp++; if ({err, resp_ch, resp_id} !== {1'b1, 1'b1, 4'd6}) begin n_bad++; $display("FAIL unknown_err: got e%b ch%0d id%0d want e1 ch1 id6", err, resp_ch, resp_id); end
      n_cmp++; if ({sync_y, inv_y, coh_y, wb_y, mem_v} !== 5'b0) begin n_bad++; $display("FAIL unknown_others: got %b want 00000", {sync_y, inv_y, coh_y, wb_y, mem_v}); end
      step(); #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL unknown_once: got %b want 0", err); end
   endtask

   task automatic test_reset_midstream();
      hdr_in[29:0] = mk(WB, 16'h2000, 3'd6, 4'd7);
      hdr_v = 2'b01; data_v = 2'b01; data_in[63:0] = pat(0); mem_ready = 1'b1;
      step(); hdr_v = 2'b00;
      for (int k = 0; k < 3; k++) begin
         data_in[63:0] = pat(k);
         step();
      end
      data_in[63:0] = pat(3); reset = 1'b1;
      step(); reset = 1'b0; #1;
      n_cmp++; if ({hdr_rdy, pw_v, data_rdy} !== 5'b11000) begin n_bad++; $display("FAIL midreset_state: got rdy%b pw%b drdy%b want rdy11 pw0 drdy00", hdr_rdy, pw_v, data_rdy); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if ({wb_y, mem_v} !== 2'b00) begin n_bad++; $display("FAIL midreset_quiet %0d: got wb%b v%b want wb0 v0", k, wb_y, mem_v); end
         step(); #1;
      end
      data_v = 2'b00;
      hdr_in = {mk(COH, 16'h0600, 3'd0, 4'd2), mk(COH, 16'h0500, 3'd0, 4'd1)};
      hdr_v = 2'b11;
      step(); hdr_v = 2'b00; #1;
      n_cmp++; if (coh_y !== 1'b1) begin n_bad++; $display("FAIL midreset_coh_a: got %b want 1", coh_y); end
      step(); #1;
      n_cmp++; if (coh_y !== 1'b1) begin n_bad++; $display("FAIL midreset_coh_b: got %b want 1", coh_y); end
      step(); #1;
      n_cmp++; if ({pw_v, pw_addr} !== {1'b1, 16'h0500}) begin n_bad++; $display("FAIL midreset_q: got v%b a%h want v1 a0500", pw_v, pw_addr); end
      pw_yumi = 1'b1;
      step(); step(); pw_yumi = 1'b0; #1;
      n_cmp++; if (pw_v !== 1'b0) begin n_bad++; $display("FAIL midreset_drain: got %b want 0", pw_v); end
   endtask

   task automatic test_toggle_ready();
      int sent = 0;
      int wbs  = 0;
      int cyc  = 0;
      hdr_in[59:30] = mk(WB, 16'h3000, 3'd6, 4'd9);
      hdr_v = 2'b10; data_v = 2'b10; mem_ready = 1'b0;
      step(); hdr_v = 2'b00;
      while (wbs == 0 && cyc < 40) begin
         mem_ready = (cyc % 2 == 1);
         data_in[127:64] = pat(sent + 16);
         #1;
         if (mem_v && mem_ready) begin
            n_cmp++; if (mem_data !== pat(sent + 16)) begin n_bad++; $display("FAIL tog_data beat %0d: got %h want %h", sent, mem_data, pat(sent + 16)); end
            n_cmp++; if ({mem_last, data_rdy} !== {(sent == 7), 2'b10}) begin n_bad++; $display("FAIL tog_last beat %0d: got last%b rdy%b want last%b rdy10", sent, mem_last, data_rdy, (sent == 7)); end
            sent++;
         end else if (mem_v) begin
            n_cmp++; if (data_rdy !== 2'b00) begin n_bad++; $display("FAIL tog_stall_rdy: got %b want 00", data_rdy); end
         end
         if (wb_y) wbs++;
         step();
         cyc++;
      end
      data_v = 2'b00; mem_ready = 1'b0; #1;
      n_cmp++; if ({sent, wbs} !== {32'd8, 32'd1}) begin n_bad++; $display("FAIL tog_count: got beats %0d wb %0d after %0d cycles want beats 8 wb 1", sent, wbs, cyc); end
      n_cmp++; if ({wb_y, pw_v, pw_addr, up} !== {1'b0, 1'b1, 16'h3000, 1'b1}) begin n_bad++; $display("FAIL tog_pending: got wb%b v%b a%h up%b want wb0 v1 a3000 up1", wb_y, pw_v, pw_addr, up); end
      pw_yumi = 1'b1;
      step(); pw_yumi = 1'b0;
   endtask

   initial begin
      reset = 1'b1; hdr_in = '0; hdr_v = '0; has_data = '0; data_in = '0; data_v = '0;
      last_in = '0; mem_ready = 1'b0; pw_yumi = 1'b0;
      test_reset();
      test_sync_inv();
      test_wb();
      test_coh_full();
      test_unknown();
      test_reset_midstream();
      test_toggle_ready();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/bp_cce_hybrid_lce_resp_pipe_mc.md
Name: bp_cce_hybrid_lce_resp_pipe_mc

Overview:
Multi-channel LCE response pipe for the hybrid CCE. It accepts num_ch_p independent BedRock burst LCE response channels and arbitrates between them round-robin. Writeback (wb) data is forwarded to a single BedRock stream memory command output, and all other responses become control pulses. Pending-bit updates go through a pending_els_p-deep queue, so coh_ack and wb responses no longer stall the pipe for one cycle each waiting on pending_w_yumi_i.

Parameters:
bp_params_p, e_bp_default_cfg, processor configuration; supplies paddr_width_p, lce_id_width_p, cce_block_width_p.
lce_data_width_p, dword_width_gp, LCE response data beat width.
mem_data_width_p, dword_width_gp, memory command stream beat width; must equal lce_data_width_p.
num_ch_p, 2, number of LCE response input channels (>=1).
header_els_p, 2, header FIFO depth per channel (>=2).
pending_els_p, 4, pending-write queue depth (>=1).

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
lce_resp_header_i  in  num_ch_p*hdr_w  per-channel LCE response headers, packed
lce_resp_header_v_i  in  num_ch_p  header valid
lce_resp_header_ready_and_o  out  num_ch_p  header FIFO not full
lce_resp_has_data_i  in  num_ch_p  header carries data
lce_resp_data_i  in  num_ch_p*lce_data_width_p  data beats
lce_resp_data_v_i  in  num_ch_p  data valid
lce_resp_data_ready_and_o  out  num_ch_p  data accepted
lce_resp_last_i  in  num_ch_p  unused
mem_cmd_header_o  out  mem_hdr_w  stream header
mem_cmd_data_o  out  mem_data_width_p  stream data
mem_cmd_v_o  out  1  stream valid
mem_cmd_ready_and_i  in  1  stream ready
mem_cmd_last_o  out  1  last beat
pending_w_v_o  out  1  queue head valid
pending_w_yumi_i  in  1  head consumed
pending_w_addr_o  out  paddr_width_p  head address
pending_w_addr_bypass_hash_o  out  1  constant 0
pending_up_o / pending_down_o / pending_clear_o  out  1 each  head direction; clear is constant 0
sync_yumi_o, inv_yumi_o, coh_yumi_o, wb_yumi_o  out  1 each  single-cycle consume pulses
resp_ch_o  out  clog2(num_ch_p)  channel of the current pulse
resp_lce_id_o  out  lce_id_width_p  payload.src_id of the current pulse
resp_error_o  out  1  pulse on an unrecognised msg_type

Behaviour:
- Each channel has a bsg_fifo_1r1w_small of width {has_data, header} and depth header_els_p.
- Reset: FIFOs empty; pending queue empty; arbiter pointer at channel 0; lock cleared. Every output is 0 except lce_resp_header_ready_and_o, which is all-1 from the first cycle after reset.
- Arbitration: round-robin over channels whose FIFO head is valid. The grant is held (locked) from the cycle the wb stream pump starts a new stream until fsm_done. The pointer advances to grant+1 only when the granted header is yumi'd. At most one header is consumed per cycle.
- Decode of the granted head:
  - sync_ack: consume the head; sync_yumi_o=1.
  - inv_ack: consume the head; inv_yumi_o=1.
  - null_wb: consume the head; wb_yumi_o=1; no pending entry.
  - coh_ack: consume the head and enqueue {addr, down} only if the queue is not full; otherwise hold the head with no pulse. coh_yumi_o=1 on consume.
  - wb: mem_cmd base header = {addr, size, subop, e_bedrock_mem_wr, payload.lce_id=src_id}.
    - mem_cmd_v = head_v & data_v[grant].
    - data_ready_and[grant] = head_v & pump_ready.
    - The first beat may not start unless the queue has a free entry.
    - One entry is reserved at stream start. On pump fsm_done: enqueue {addr, up}, consume the head, wb_yumi_o=1.
  - Other msg_type: consume the head; resp_error_o=1.
- Non-granted channels: lce_resp_data_ready_and_o = 0.
- Zero-cycle fall-through for control: a pulse appears in the same cycle the header is at the FIFO head. Minimum latency from input header to pulse is 1 cycle, through the FIFO.
- Pending queue:
  - FIFO order; the head drives the pending_w_* outputs.
  - Enqueue and dequeue in the same cycle are allowed, including when full, provided the reservation counter permits.
  - Full means occupancy + reservations == pending_els_p.
- Reset mid-stream: lock, reservation and partial pump state are discarded. The next cycle behaves as after reset.

Optional Feature:
BP_CCE_RESP_PIPE_PERF_EN.
- Defined: adds outputs wb_count_o [31:0], coh_count_o [31:0] and pending_full_stall_o [31:0].
  - wb_count_o and coh_count_o increment on wb_yumi (wb only, not null_wb) and on coh_yumi respectively.
  - pending_full_stall_o counts cycles in which a coh_ack or wb head is blocked solely by a full queue.
  - All three counters saturate at 2^32-1 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- num_ch_p=2: sync_ack on ch0 and inv_ack on ch1 in the same cycle -> sync_yumi pulses first with resp_ch_o=0, then inv_yumi in the next cycle with resp_ch_o=1.
- ch0 wb to 0x1000, 64B block, mem_data 64b, with ch1 sync_ack pending -> 8 beats are emitted with mem_cmd_last_o on beat 8. sync_yumi does not pulse until the cycle after wb_yumi. The pending queue then holds {0x1000, up}.
- pending_els_p=2 with pending_w_yumi_i held 0, three coh_acks to 0x40, 0x80, 0xC0 -> two coh_yumi pulses. The third is held and the stall counter increments. Raising yumi releases the third, which is enqueued in the same cycle as the dequeue.
- Unknown msg_type header -> consumed in 1 cycle with resp_error_o=1 and no other pulse.
- Reset asserted on beat 3 of a wb -> after reset, ready_and is all-1, pending_w_v_o=0 and no wb_yumi pulse occurs.
- mem_cmd_ready_and_i toggled 1/0 every cycle during a wb -> beats are accepted only when ready, data order is preserved, and exactly 8 beats are sent.
